// File: rtl/prco_mem_ctrl_if.sv
// Request/response and local-memory strobe bundle for prco_mem_ctrl.
// master = the controller itself; slave = pipeline stages plus local memory.
interface prco_mem_ctrl_if;
  logic        i_fetch_req;
  logic [15:0] i_fetch_addr;
  logic        q_fetch_ack;
  logic        q_fetch_valid;
  logic [15:0] q_fetch_instr;

  logic        i_data_req;
  logic        i_data_we;
  logic [15:0] i_data_addr;
  logic [15:0] i_data_wdata;
  logic        q_data_ack;
  logic        q_data_valid;
  logic [15:0] q_data_rdata;

  logic        q_ce_fetch;
  logic        q_ce_alu;
  logic        q_mem_we;
  logic [15:0] q_mem_addr;
  logic [15:0] q_mem_dina;
  logic        i_ce_dec;
  logic        i_ce_reg;
  logic [15:0] i_mem_douta;

  logic        q_busy;
  logic        q_err;

  modport master (
    input  i_fetch_req, i_fetch_addr, i_data_req, i_data_we, i_data_addr, i_data_wdata,
    input  i_ce_dec, i_ce_reg, i_mem_douta,
    output q_fetch_ack, q_fetch_valid, q_fetch_instr,
    output q_data_ack, q_data_valid, q_data_rdata,
    output q_ce_fetch, q_ce_alu, q_mem_we, q_mem_addr, q_mem_dina,
    output q_busy, q_err
  );

  modport slave (
    output i_fetch_req, i_fetch_addr, i_data_req, i_data_we, i_data_addr, i_data_wdata,
    output i_ce_dec, i_ce_reg, i_mem_douta,
    input  q_fetch_ack, q_fetch_valid, q_fetch_instr,
    input  q_data_ack, q_data_valid, q_data_rdata,
    input  q_ce_fetch, q_ce_alu, q_mem_we, q_mem_addr, q_mem_dina,
    input  q_busy, q_err
  );
endinterface

// File: rtl/prco_mem_ctrl.sv
// PRCO memory-access initiator: arbitrates fetch vs. load/store (data first),
// issues one single-cycle strobe per access and returns the result or a timeout.
module prco_mem_ctrl #(
  parameter int unsigned P_TIMEOUT = 15
) (
  input  logic           i_clk,
  input  logic           i_reset,
  prco_mem_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE_F, WAIT_F, ISSUE_D, WAIT_D} state_t;

  localparam logic [3:0] CNT_LAST = 4'(P_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fetch_ack_q, fetch_ack_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [15:0] fetch_instr_q, fetch_instr_d;
  logic        data_ack_q, data_ack_d;
  logic        data_valid_q, data_valid_d;
  logic [15:0] data_rdata_q, data_rdata_d;
  logic        ce_fetch_q, ce_fetch_d;
  logic        ce_alu_q, ce_alu_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_dina_q, mem_dina_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        cooldown;

  // The IDLE cycle carrying a valid/err pulse never accepts, which leaves the
  // requester one clean IDLE cycle before the next strobe.
  assign cooldown = fetch_valid_q | data_valid_q | err_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fetch_ack_d   = 1'b0;
    fetch_valid_d = 1'b0;
    fetch_instr_d = fetch_instr_q;
    data_ack_d    = 1'b0;
    data_valid_d  = 1'b0;
    data_rdata_d  = data_rdata_q;
    ce_fetch_d    = 1'b0;
    ce_alu_d      = 1'b0;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_dina_d    = mem_dina_q;
    err_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!cooldown) begin
          if (bus.i_data_req) begin
            mem_addr_d = bus.i_data_addr;
            mem_we_d   = bus.i_data_we;
            mem_dina_d = bus.i_data_wdata;
            ce_alu_d   = 1'b1;
            data_ack_d = 1'b1;
            state_d    = ISSUE_D;
          end else if (bus.i_fetch_req) begin
            mem_addr_d  = bus.i_fetch_addr;
            mem_we_d    = 1'b0;
            ce_fetch_d  = 1'b1;
            fetch_ack_d = 1'b1;
            state_d     = ISSUE_F;
          end
        end
      end
      ISSUE_F: begin
        cnt_d   = 4'd0;
        state_d = WAIT_F;
      end
      ISSUE_D: begin
        cnt_d   = 4'd0;
        state_d = WAIT_D;
      end
      WAIT_F: begin
        if (bus.i_ce_dec) begin
          fetch_instr_d = bus.i_mem_douta;
          fetch_valid_d = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WAIT_D: begin
        if (bus.i_ce_reg) begin
          if (!mem_we_q) data_rdata_d = bus.i_mem_douta;
          data_valid_d = 1'b1;
          mem_we_d     = 1'b0;
          state_d      = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d    = 1'b1;
          mem_we_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        mem_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      fetch_ack_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= 16'h0000;
      data_ack_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      data_rdata_q  <= 16'h0000;
      ce_fetch_q    <= 1'b0;
      ce_alu_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 16'h0000;
      mem_dina_q    <= 16'h0000;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fetch_ack_q   <= fetch_ack_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      data_ack_q    <= data_ack_d;
      data_valid_q  <= data_valid_d;
      data_rdata_q  <= data_rdata_d;
      ce_fetch_q    <= ce_fetch_d;
      ce_alu_q      <= ce_alu_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_dina_q    <= mem_dina_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign bus.q_fetch_ack   = fetch_ack_q;
  assign bus.q_fetch_valid = fetch_valid_q;
  assign bus.q_fetch_instr = fetch_instr_q;
  assign bus.q_data_ack    = data_ack_q;
  assign bus.q_data_valid  = data_valid_q;
  assign bus.q_data_rdata  = data_rdata_q;
  assign bus.q_ce_fetch    = ce_fetch_q;
  assign bus.q_ce_alu      = ce_alu_q;
  assign bus.q_mem_we      = mem_we_q;
  assign bus.q_mem_addr    = mem_addr_q;
  assign bus.q_mem_dina    = mem_dina_q;
  assign bus.q_busy        = busy_q;
  assign bus.q_err         = err_q;
endmodule

// File: tb/tb_prco_mem_ctrl.sv
// Bench for prco_mem_ctrl: local memory responder, transaction-level reference
// model compared every cycle, directed scenarios plus randomized traffic.
module tb_prco_mem_ctrl;
  localparam int TMO = 15;

  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  always #5 i_clk = ~i_clk;

  prco_mem_ctrl_if bus();
  prco_mem_ctrl #(.P_TIMEOUT(TMO)) dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Local memory: done one cycle after the strobe edge (+mem_delay), or never when muted.
  logic [15:0] mem [0:255];
  logic mem_dec = 1'b0, mem_reg = 1'b0;
  logic man_dec = 1'b0, man_reg = 1'b0;
  logic rnd_dec = 1'b0, rnd_reg = 1'b0;
  logic mute = 1'b0, rand_spur = 1'b0;
  int   mem_delay = 0;
  logic       r_f;
  logic [7:0] r_a;

  assign bus.i_ce_dec = mem_dec | man_dec | rnd_dec;
  assign bus.i_ce_reg = mem_reg | man_reg | rnd_reg;

  always begin
    @(negedge i_clk);
    if (i_reset && (bus.q_ce_fetch || bus.q_ce_alu)) begin
      r_f = bus.q_ce_fetch;
      r_a = bus.q_mem_addr[7:0];
      if (bus.q_ce_alu && bus.q_mem_we) mem[r_a] = bus.q_mem_dina;
      repeat (mem_delay + 1) @(posedge i_clk);
      #1;
      if (!mute) begin
        bus.i_mem_douta = mem[r_a];
        if (r_f) mem_dec = 1'b1;
        else     mem_reg = 1'b1;
      end
      @(posedge i_clk);
      #1;
      mem_dec = 1'b0;
      mem_reg = 1'b0;
      bus.i_mem_douta = 16'($urandom);
    end
  end

  always begin
    @(posedge i_clk);
    #1;
    rnd_dec = rand_spur && ($urandom_range(0, 19) == 0);
    rnd_reg = rand_spur && ($urandom_range(0, 19) == 0);
  end

  // Reference model: one outstanding access, tracked by its age in clock edges.
  logic e_fack, e_fval, e_dack, e_dval, e_cef, e_cea, e_we, e_busy, e_err;
  logic [15:0] e_instr, e_rdata, e_addr, e_dina;
  bit m_out, m_isd, m_load, m_cool;
  int m_age;

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      {e_fack, e_fval, e_dack, e_dval, e_cef, e_cea, e_we, e_busy, e_err} = '0;
      e_instr = '0; e_rdata = '0; e_addr = '0; e_dina = '0;
      m_out = 0; m_isd = 0; m_load = 0; m_cool = 0; m_age = 0;
    end else begin
      {e_fack, e_fval, e_dack, e_dval, e_cef, e_cea, e_err} = '0;
      if (m_out) begin
        m_age++;
        if (m_age >= 2 && (m_isd ? bus.i_ce_reg : bus.i_ce_dec)) begin
          if (m_isd) begin
            e_dval = 1'b1;
            if (m_load) e_rdata = bus.i_mem_douta;
          end else begin
            e_fval  = 1'b1;
            e_instr = bus.i_mem_douta;
          end
          e_we = 1'b0; m_out = 0; m_cool = 1;
        end else if (m_age == TMO + 1) begin
          e_err = 1'b1; e_we = 1'b0; m_out = 0; m_cool = 1;
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else if (bus.i_data_req) begin
        e_dack = 1'b1; e_cea = 1'b1;
        e_addr = bus.i_data_addr; e_we = bus.i_data_we; e_dina = bus.i_data_wdata;
        m_out = 1; m_isd = 1; m_load = !bus.i_data_we; m_age = 0;
      end else if (bus.i_fetch_req) begin
        e_fack = 1'b1; e_cef = 1'b1;
        e_addr = bus.i_fetch_addr; e_we = 1'b0;
        m_out = 1; m_isd = 0; m_age = 0;
      end
      e_busy = m_out;
    end
  end

  bit cmp_en = 0;
  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("fetch_ack", bus.q_fetch_ack, e_fack);
      chk("fetch_valid", bus.q_fetch_valid, e_fval);
      chk("fetch_instr", bus.q_fetch_instr, e_instr);
      chk("data_ack", bus.q_data_ack, e_dack);
      chk("data_valid", bus.q_data_valid, e_dval);
      chk("data_rdata", bus.q_data_rdata, e_rdata);
      chk("ce_fetch", bus.q_ce_fetch, e_cef);
      chk("ce_alu", bus.q_ce_alu, e_cea);
      chk("mem_we", bus.q_mem_we, e_we);
      chk("mem_addr", bus.q_mem_addr, e_addr);
      chk("mem_dina", bus.q_mem_dina, e_dina);
      chk("busy", bus.q_busy, e_busy);
      chk("err", bus.q_err, e_err);
      if (bus.q_mem_we && !bus.q_busy && !bus.q_ce_alu) fail_now("we_without_data_access");
    end
  end

  // Requesters: raise req, hold until the ack is seen, drop at the following edge.
  logic        ack_ce, ack_we;
  logic [15:0] ack_addr;
  longint      t_fack, t_dack;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic req_fetch(input logic [15:0] a);
    int t = 0;
    bus.i_fetch_addr = a;
    bus.i_fetch_req  = 1'b1;
    do begin @(negedge i_clk); t++; end while (!bus.q_fetch_ack && t < 60);
    if (!bus.q_fetch_ack) fail_now("fetch_ack_wait");
    t_fack = $time;
    ack_ce = bus.q_ce_fetch; ack_we = bus.q_mem_we; ack_addr = bus.q_mem_addr;
    step();
    bus.i_fetch_req = 1'b0;
  endtask

  task automatic req_data(input logic we, input logic [15:0] a, input logic [15:0] wd);
    int t = 0;
    bus.i_data_we = we; bus.i_data_addr = a; bus.i_data_wdata = wd;
    bus.i_data_req = 1'b1;
    do begin @(negedge i_clk); t++; end while (!bus.q_data_ack && t < 60);
    if (!bus.q_data_ack) fail_now("data_ack_wait");
    t_dack = $time;
    ack_ce = bus.q_ce_alu; ack_we = bus.q_mem_we; ack_addr = bus.q_mem_addr;
    step();
    bus.i_data_req = 1'b0;
  endtask

  task automatic wait_sig(input int which, output int lat);
    logic s;
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
      case (which)
        0:       s = bus.q_fetch_valid;
        1:       s = bus.q_data_valid;
        default: s = bus.q_err;
      endcase
    end while (!s && lat < 40);
    if (!s) fail_now("pulse_wait");
  endtask

  task automatic settle();
    int t = 0;
    while (bus.q_busy && t < 60) begin @(negedge i_clk); t++; end
    if (bus.q_busy) fail_now("settle");
    repeat (2) @(negedge i_clk);
    step();
  endtask

  initial begin
    int lat;
    int mode;
    logic [15:0] a, wd;
    bus.i_fetch_req = 0; bus.i_fetch_addr = 0;
    bus.i_data_req = 0; bus.i_data_we = 0; bus.i_data_addr = 0; bus.i_data_wdata = 0;
    bus.i_mem_douta = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h1357) ^ 16'hA5A5;
    mem[3] = 16'h6820; mem[1] = 16'h4321; mem[16] = 16'h1111; mem[32] = 16'h2222;
    mem[8'h50] = 16'hBEEF;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_busy", bus.q_busy, 16'h0);
    chk("reset_addr", bus.q_mem_addr, 16'h0);
    chk("reset_instr", bus.q_fetch_instr, 16'h0);
    cmp_en = 1;
    #2 i_reset = 1'b1;
    step();

    // Single fetch
    req_fetch(16'h0003);
    chk("fetch_strobe", ack_ce, 16'h1);
    chk("fetch_addr", ack_addr, 16'h0003);
    chk("fetch_we", ack_we, 16'h0);
    wait_sig(0, lat);
    chk("fetch_valid_delay", 16'(lat), 16'd2);
    chk("fetch_data", bus.q_fetch_instr, 16'h6820);
    settle();

    // Store then load
    req_data(1'b1, 16'h00AB, 16'h00CD);
    chk("store_we_with_strobe", {ack_ce, ack_we}, 16'h3);
    wait_sig(1, lat);
    chk("store_rdata_kept", bus.q_data_rdata, 16'h0000);
    settle();
    req_data(1'b0, 16'h00AB, 16'h0000);
    wait_sig(1, lat);
    chk("load_data", bus.q_data_rdata, 16'h00CD);
    settle();

    // Simultaneous fetch and data: data first, fetch four cycles later
    fork
      req_data(1'b0, 16'h0010, 16'h0);
      req_fetch(16'h0020);
    join
    chk("fetch_after_data", 16'((t_fack - t_dack) / 10), 16'd4);
    settle();
    chk("prio_load", bus.q_data_rdata, 16'h1111);
    chk("prio_fetch", bus.q_fetch_instr, 16'h2222);

    // Timeout
    mute = 1'b1;
    req_fetch(16'h0030);
    wait_sig(2, lat);
    chk("timeout_delay", 16'(lat), 16'd16);
    chk("timeout_busy", bus.q_busy, 16'h0);
    settle();
    mute = 1'b0;
    req_data(1'b0, 16'h0003, 16'h0);
    wait_sig(1, lat);
    chk("after_timeout_load", bus.q_data_rdata, 16'h6820);
    settle();

    // Asynchronous reset in WAIT_D
    req_data(1'b0, 16'h0040, 16'h0);
    #2 i_reset = 1'b0;
    #1;
    chk("arst_fetch_instr", bus.q_fetch_instr, 16'h0);
    chk("arst_rdata", bus.q_data_rdata, 16'h0);
    chk("arst_addr", bus.q_mem_addr, 16'h0);
    chk("arst_busy", bus.q_busy, 16'h0);
    chk("arst_strobes", {bus.q_ce_fetch, bus.q_ce_alu, bus.q_mem_we, bus.q_err}, 16'h0);
    chk("arst_pulses", {bus.q_fetch_ack, bus.q_fetch_valid, bus.q_data_ack, bus.q_data_valid}, 16'h0);
    repeat (2) @(negedge i_clk);
    #2 i_reset = 1'b1;
    step();
    req_fetch(16'h0001);
    wait_sig(0, lat);
    chk("post_reset_fetch", bus.q_fetch_instr, 16'h4321);
    settle();

    // Spurious done in IDLE and wrong-kind done in WAIT_F
    man_dec = 1'b1; man_reg = 1'b1;
    step();
    man_dec = 1'b0; man_reg = 1'b0;
    step();
    mem_delay = 3;
    req_fetch(16'h0050);
    man_reg = 1'b1;
    fork
      wait_sig(0, lat);
      begin step(); man_reg = 1'b0; end
    join
    chk("spur_fetch_delay", 16'(lat), 16'd5);
    chk("spur_fetch_data", bus.q_fetch_instr, 16'hBEEF);
    settle();

    // Randomized traffic
    rand_spur = 1'b1;
    for (int it = 0; it < 150; it++) begin
      mode = $urandom_range(0, 2);
      mute = ($urandom_range(0, 9) == 0);
      mem_delay = $urandom_range(0, 2);
      a = 16'($urandom_range(0, 255));
      wd = 16'($urandom);
      case (mode)
        0: req_fetch(a);
        1: req_data(1'($urandom_range(0, 1)), a, wd);
        default: fork
          req_data(1'($urandom_range(0, 1)), a, wd);
          req_fetch(16'($urandom_range(0, 255)));
        join
      endcase
      settle();
    end
    rand_spur = 1'b0;
    mute = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
